// File: rtl/mp_alu_sequencer.sv
// Multi-precision sequencer: walks NBYTES limbs through an 8-bit ALU, chaining the carry/shift bit.
// Optional macro MP_CMP_EARLY_EXIT_EN: COMP stops at the first unequal limb.
module mp_alu_sequencer #(
   parameter int NBYTES = 2
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  START,
   input  logic [2:0]            CMD,
   input  logic                  CIN,
   input  logic [8*NBYTES-1:0]   A_IN,
   input  logic [8*NBYTES-1:0]   B_IN,
   output logic [2:0]            ALU_OP,
   output logic [7:0]            ALU_A,
   output logic [7:0]            ALU_B,
   output logic                  ALU_SC_IN,
   input  logic [7:0]            ALU_OUT,
   input  logic                  ALU_SC_OUT,
   input  logic                  ALU_ZERO,
   input  logic                  ALU_GREATER,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [8*NBYTES-1:0]   RESULT,
   output logic                  COUT,
   output logic                  ZFLAG,
   output logic                  GFLAG
);

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   localparam logic [2:0] K_ADD  = 3'd0;
   localparam logic [2:0] K_LSH  = 3'd1;
   localparam logic [2:0] K_RSH  = 3'd2;
   localparam logic [2:0] K_XOR  = 3'd3;
   localparam logic [2:0] K_AND  = 3'd4;
   localparam logic [2:0] K_COMP = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              state, state_nxt;
   logic [2:0]          cmd_q;
   logic [8*NBYTES-1:0] a_q, b_q;
   logic [IW-1:0]       idx;
   logic                carry, zacc, gflag_q, found, cout_q;
   logic                walk_down, chained, last_limb, exit_run;

   assign walk_down = (cmd_q == K_RSH) || (cmd_q == K_COMP);
   assign chained   = (cmd_q == K_ADD) || (cmd_q == K_LSH) || (cmd_q == K_RSH);
   assign last_limb = walk_down ? (idx == '0) : (idx == LAST);

`ifdef MP_CMP_EARLY_EXIT_EN
   assign exit_run = last_limb || ((cmd_q == K_COMP) && !ALU_ZERO);
`else
   assign exit_run = last_limb;
`endif

   assign BUSY   = (state != S_IDLE);
   assign DONE   = (state == S_DONE);
   assign COUT   = cout_q;
   assign ZFLAG  = zacc;
   assign GFLAG  = gflag_q;

   always_comb begin
      state_nxt = state;
      ALU_OP    = 3'd0;
      ALU_A     = 8'd0;
      ALU_B     = 8'd0;
      ALU_SC_IN = 1'b0;
      case (state)
         S_IDLE: begin
            // Reserved commands skip the ALU entirely.
            if (START) state_nxt = (CMD > K_COMP) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            ALU_OP    = cmd_q;
            ALU_A     = a_q[{idx, 3'b000} +: 8];
            ALU_B     = ((cmd_q == K_LSH) || (cmd_q == K_RSH)) ? 8'd0 : b_q[{idx, 3'b000} +: 8];
            ALU_SC_IN = chained ? carry : 1'b0;
            if (exit_run) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= S_IDLE;
         cmd_q   <= 3'd0;
         a_q     <= '0;
         b_q     <= '0;
         idx     <= '0;
         carry   <= 1'b0;
         zacc    <= 1'b0;
         gflag_q <= 1'b0;
         found   <= 1'b0;
         cout_q  <= 1'b0;
         RESULT  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (START) begin
                  cmd_q   <= CMD;
                  a_q     <= A_IN;
                  b_q     <= B_IN;
                  carry   <= CIN;
                  RESULT  <= '0;
                  zacc    <= 1'b1;
                  gflag_q <= 1'b0;
                  found   <= 1'b0;
                  cout_q  <= 1'b0;
                  idx     <= ((CMD == K_RSH) || (CMD == K_COMP)) ? LAST : '0;
               end
            end
            S_RUN: begin
               carry <= ALU_SC_OUT;
               if (cmd_q == K_COMP) begin
                  // Only the most significant unequal limb decides the flags.
                  if (!found && !ALU_ZERO) begin
                     found   <= 1'b1;
                     zacc    <= 1'b0;
                     gflag_q <= ALU_GREATER;
                  end
               end else begin
                  RESULT[{idx, 3'b000} +: 8] <= ALU_OUT;
                  zacc <= zacc & (ALU_OUT == 8'd0);
               end
               if (exit_run) cout_q <= chained ? ALU_SC_OUT : 1'b0;
               else          idx    <= walk_down ? idx - 1'b1 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mp_alu_sequencer.sv
// Bench for mp_alu_sequencer: behavioural 8-bit ALU, directed vector table, corner sequences,
// and random commands checked against a whole-word reference model.
module tb_mp_alu_sequencer;

   localparam int NB = 2;
   localparam int W  = 8 * NB;

`ifdef MP_CMP_EARLY_EXIT_EN
   localparam int LAT_MSB_DIFF = 2;
`else
   localparam int LAT_MSB_DIFF = 3;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   cmd = 3'd0;
   logic         cin = 1'b0;
   logic [W-1:0] a_in = '0, b_in = '0;
   logic [2:0]   alu_op;
   logic [7:0]   alu_a, alu_b, alu_out;
   logic         alu_sc_in, alu_sc_out, alu_zero, alu_greater;
   logic         busy, done, cout, zflag, gflag;
   logic [W-1:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mp_alu_sequencer #(.NBYTES(NB)) dut (
      .CLK(clk), .RESET_N(rst_n), .START(start), .CMD(cmd), .CIN(cin),
      .A_IN(a_in), .B_IN(b_in), .ALU_OP(alu_op), .ALU_A(alu_a), .ALU_B(alu_b),
      .ALU_SC_IN(alu_sc_in), .ALU_OUT(alu_out), .ALU_SC_OUT(alu_sc_out),
      .ALU_ZERO(alu_zero), .ALU_GREATER(alu_greater), .BUSY(busy), .DONE(done),
      .RESULT(result), .COUT(cout), .ZFLAG(zflag), .GFLAG(gflag)
   );

   // Behavioural 8-bit ALU
   always_comb begin
      alu_out     = 8'd0;
      alu_sc_out  = 1'b0;
      alu_zero    = 1'b0;
      alu_greater = 1'b0;
      case (alu_op)
         3'd0: {alu_sc_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_sc_in};
         3'd1: begin alu_out = {alu_a[6:0], alu_sc_in}; alu_sc_out = alu_a[7]; end
         3'd2: begin alu_out = {alu_sc_in, alu_a[7:1]}; alu_sc_out = alu_a[0]; end
         3'd3: alu_out = alu_a ^ alu_b;
         3'd4: alu_out = alu_a & alu_b;
         3'd5: begin alu_zero = (alu_a == alu_b); alu_greater = (alu_a > alu_b); end
         default: ;
      endcase
   end

   typedef struct {
      logic [2:0]   cmd;
      logic         cin;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         c;
      logic         z;
      logic         g;
      int           lat;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Whole-word reference: each command evaluated on the full operands at once.
   task automatic model(input logic [2:0] m_cmd, input logic m_cin, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] res, output logic c,
                        output logic z, output logic g, output int lat);
      logic [W:0] wide;
      int k;
      res = '0; c = 1'b0; z = 1'b0; g = 1'b0; lat = NB + 1;
      case (m_cmd)
         3'd0: begin
            wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, m_cin};
            res = wide[W-1:0]; c = wide[W];
         end
         3'd1: {c, res} = {a, m_cin};
         3'd2: {res, c} = {m_cin, a};
         3'd3: res = a ^ b;
         3'd4: res = a & b;
         3'd5: begin
            z = (a == b);
            g = (a > b);
`ifdef MP_CMP_EARLY_EXIT_EN
            k = 0;
            for (int i = NB - 1; i >= 0; i--) begin
               k++;
               if (a[8*i +: 8] != b[8*i +: 8]) break;
            end
            lat = k + 1;
`else
            k = NB;
`endif
         end
         default: begin z = 1'b1; lat = 1; end
      endcase
      if (m_cmd <= 3'd4) z = (res == '0);
   endtask

   task automatic run_op(input logic [2:0] t_cmd, input logic t_cin, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] res, output logic c,
                         output logic z, output logic g, output int lat, output logic seen);
      @(negedge clk);
      start = 1'b1; cmd = t_cmd; cin = t_cin; a_in = a; b_in = b;
      lat = 0; seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
         if (done) begin seen = 1'b1; break; end
      end
      res = result; c = cout; z = zflag; g = gflag;
   endtask

   task automatic post_idle_checks();
      @(posedge clk); #1;
      check("done_one_cycle", done, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_alu_a", alu_a, 8'd0);
      check("idle_alu_b", alu_b, 8'd0);
      check("idle_alu_sc_in", alu_sc_in, 1'b0);
   endtask

   task automatic apply_and_check(input string tag, input logic [2:0] t_cmd, input logic t_cin,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] e_res, input logic e_c, input logic e_z,
                                  input logic e_g, input int e_lat);
      logic [W-1:0] r;
      logic c, z, g, seen;
      int lat;
      run_op(t_cmd, t_cin, a, b, r, c, z, g, lat, seen);
      check({tag, "_done_seen"}, seen, 1'b1);
      check({tag, "_latency"}, lat, e_lat);
      check({tag, "_result"}, r, e_res);
      check({tag, "_cout"}, c, e_c);
      check({tag, "_zflag"}, z, e_z);
      check({tag, "_gflag"}, g, e_g);
      post_idle_checks();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] r, ra, rb, e_res;
      logic e_c, e_z, e_g;
      int e_lat, ndone;
      logic [2:0] rc;
      logic rcin;

      vecs[0]  = '{3'd0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 3};
      vecs[1]  = '{3'd0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 3};
      vecs[2]  = '{3'd0, 1'b1, 16'hFFFF, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 3};
      vecs[3]  = '{3'd1, 1'b1, 16'h8001, 16'h1234, 16'h0003, 1'b1, 1'b0, 1'b0, 3};
      vecs[4]  = '{3'd2, 1'b1, 16'h0001, 16'h1234, 16'h8000, 1'b1, 1'b0, 1'b0, 3};
      vecs[5]  = '{3'd5, 1'b0, 16'h1200, 16'h1100, 16'h0000, 1'b0, 1'b0, 1'b1, LAT_MSB_DIFF};
      vecs[6]  = '{3'd5, 1'b0, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b1, 1'b0, 3};
      vecs[7]  = '{3'd3, 1'b1, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0, 1'b0, 3};
      vecs[8]  = '{3'd4, 1'b1, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b0, 1'b1, 1'b0, 3};
      vecs[9]  = '{3'd6, 1'b1, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
      vecs[10] = '{3'd5, 1'b0, 16'h1100, 16'h1200, 16'h0000, 1'b0, 1'b0, 1'b0, LAT_MSB_DIFF};
      vecs[11] = '{3'd5, 1'b0, 16'h0012, 16'h0011, 16'h0000, 1'b0, 1'b0, 1'b1, 3};
      vecs[12] = '{3'd7, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1};

      // Reset state
      #12;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_result", result, '0);
      check("rst_cout", cout, 1'b0);
      check("rst_zflag", zflag, 1'b0);
      check("rst_gflag", gflag, 1'b0);
      check("rst_alu_op", alu_op, 3'd0);
      check("rst_alu_a", alu_a, 8'd0);
      check("rst_alu_b", alu_b, 8'd0);
      check("rst_alu_sc_in", alu_sc_in, 1'b0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 13; i++)
         apply_and_check($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].cin, vecs[i].a, vecs[i].b,
                         vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].g, vecs[i].lat);

      // Second START during RUN is ignored
      @(negedge clk);
      start = 1'b1; cmd = 3'd0; cin = 1'b0; a_in = 16'h00FF; b_in = 16'h0001;
      @(posedge clk); #1; start = 1'b0;
      ndone = 0; r = '0;
      @(negedge clk);
      start = 1'b1; cmd = 3'd3; cin = 1'b1; a_in = 16'hAAAA; b_in = 16'h5555;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1; start = 1'b0;
         if (done) begin ndone++; r = result; end
      end
      check("busy_start_done_count", ndone, 1);
      check("busy_start_result", r, 16'h0100);
      check("busy_start_result_held", result, 16'h0100);

      // START in the DONE cycle is ignored
      @(negedge clk);
      start = 1'b1; cmd = 3'd0; cin = 1'b0; a_in = 16'h0001; b_in = 16'h0001;
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1; start = 1'b0;
         if (done) begin ndone = 1; break; end
      end
      check("done_start_seen", ndone, 1);
      start = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF;
      @(posedge clk); #1; start = 1'b0;
      check("done_start_busy0", busy, 1'b0);
      @(posedge clk); #1;
      check("done_start_busy1", busy, 1'b0);
      check("done_start_result", result, 16'h0002);

      // Asynchronous reset in the middle of an ADD
      @(negedge clk);
      start = 1'b1; cmd = 3'd0; cin = 1'b0; a_in = 16'h1234; b_in = 16'h1111;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #2; rst_n = 1'b0; #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_result", result, '0);
      check("midrst_cout", cout, 1'b0);
      check("midrst_zflag", zflag, 1'b0);
      check("midrst_gflag", gflag, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("midrst_no_done", ndone, 0);
      apply_and_check("after_rst", 3'd0, 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 3);

      // Random commands against the whole-word model
      for (int i = 0; i < 60; i++) begin
         rc   = 3'($urandom_range(0, 7));
         rcin = 1'($urandom_range(0, 1));
         ra   = W'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = {ra[W-1 -: 8], 8'($urandom)};
            default: rb = W'($urandom);
         endcase
         model(rc, rcin, ra, rb, e_res, e_c, e_z, e_g, e_lat);
         apply_and_check($sformatf("rnd%0d_cmd%0d", i, rc), rc, rcin, ra, rb,
                         e_res, e_c, e_z, e_g, e_lat);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
